// File: rtl/i2c_reg_bank_if.sv
// Strobe-level link between the I2C simple slave (master modport) and its register back end (slave modport).
interface i2c_reg_bank_if;
  logic [7:0] i2c_addr_rw;
  logic       i2c_addr_rw_valid_stb;
  logic [7:0] i2c_data_rx;
  logic       i2c_data_rx_valid_stb;
  logic [7:0] i2c_data_tx;
  logic       i2c_data_tx_done_stb;
  logic       i2c_error_stb;
  logic       stall;

  modport master (
    output i2c_addr_rw, i2c_addr_rw_valid_stb, i2c_data_rx, i2c_data_rx_valid_stb,
           i2c_data_tx_done_stb, i2c_error_stb,
    input  i2c_data_tx, stall
  );

  modport slave (
    input  i2c_addr_rw, i2c_addr_rw_valid_stb, i2c_data_rx, i2c_data_rx_valid_stb,
           i2c_data_tx_done_stb, i2c_error_stb,
    output i2c_data_tx, stall
  );
endinterface

// File: rtl/i2c_reg_bank.sv
// Pointer-based register file behind the I2C simple slave, with a fabric-side read/write port.
// Stretches SCL for one cycle while the next read byte is fetched.
module i2c_reg_bank #(
  parameter logic [6:0]  I2C_ADDRESS = 7'h42,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  i2c_reg_bank_if.slave     i2c_bus,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic              usr_wr_en,
  input  logic [7:0]        usr_wr_data,
  output logic [7:0]        usr_rd_data,
  output logic              i2c_wr_stb,
  output logic [ADDR_W-1:0] i2c_wr_addr,
  output logic [2:0]        debug_state
);
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PTR   = 3'd1,
    ST_WR    = 3'd2,
    ST_FETCH = 3'd3,
    ST_RD    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_regs [NUM_REGS];
  logic [7:0]        r_data_tx;

  logic w_addr_match;
  logic w_bus_evt;
  logic w_ptr_load;
  logic w_reg_wr;
  logic w_ptr_inc;
  logic w_fetch;
  logic w_stall;

  assign w_addr_match = (i2c_bus.i2c_addr_rw[7:1] == I2C_ADDRESS);
  // Error and address strobes pre-empt every state-specific event.
  assign w_bus_evt    = i2c_bus.i2c_error_stb | i2c_bus.i2c_addr_rw_valid_stb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i2c_bus.i2c_error_stb) begin
      w_state_nxt = ST_IDLE;
    end else if (i2c_bus.i2c_addr_rw_valid_stb) begin
      if (!w_addr_match)              w_state_nxt = ST_IDLE;
      else if (i2c_bus.i2c_addr_rw[0]) w_state_nxt = ST_FETCH;
      else                            w_state_nxt = ST_PTR;
    end else begin
      case (r_state)
        ST_PTR:   if (i2c_bus.i2c_data_rx_valid_stb) w_state_nxt = ST_WR;
        ST_FETCH: w_state_nxt = ST_RD;
        ST_RD:    if (i2c_bus.i2c_data_tx_done_stb) w_state_nxt = ST_FETCH;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_stall    = 1'b0;
    w_fetch    = 1'b0;
    w_ptr_load = 1'b0;
    w_reg_wr   = 1'b0;
    w_ptr_inc  = 1'b0;
    case (r_state)
      ST_PTR:   w_ptr_load = !w_bus_evt && i2c_bus.i2c_data_rx_valid_stb;
      ST_WR:    w_reg_wr   = !w_bus_evt && i2c_bus.i2c_data_rx_valid_stb;
      ST_FETCH: begin
        w_stall = 1'b1;
        w_fetch = 1'b1;
      end
      ST_RD:    w_ptr_inc  = !w_bus_evt && i2c_bus.i2c_data_tx_done_stb;
      default:  w_stall    = 1'b0;
    endcase
    if (w_reg_wr) w_ptr_inc = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_ptr_load) begin
      r_ptr <= i2c_bus.i2c_data_rx[ADDR_W-1:0];
    end else if (w_ptr_inc) begin
      r_ptr <= r_ptr + ADDR_W'(1);
    end
  end

  // I2C write is applied last so it wins a same-register collision with the fabric.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (usr_wr_en) r_regs[usr_addr] <= usr_wr_data;
      if (w_reg_wr)  r_regs[r_ptr]    <= i2c_bus.i2c_data_rx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_tx   <= '0;
      usr_rd_data <= '0;
      i2c_wr_stb  <= 1'b0;
      i2c_wr_addr <= '0;
    end else begin
      if (w_fetch) r_data_tx <= r_regs[r_ptr];
      usr_rd_data <= r_regs[usr_addr];
      i2c_wr_stb  <= w_reg_wr;
      if (w_reg_wr) i2c_wr_addr <= r_ptr;
    end
  end

  assign i2c_bus.stall       = w_stall;
  assign i2c_bus.i2c_data_tx = r_data_tx;
  assign debug_state         = 3'(r_state);
endmodule

// File: tb/tb_i2c_reg_bank.sv
// Scoreboard bench for i2c_reg_bank: directed scenarios plus randomized traffic against a
// transaction-level model (register array, pointer, transaction mode).
module tb_i2c_reg_bank;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREGS  = 16;
  localparam logic [6:0]  DEV    = 7'h42;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] usr_addr = '0;
  logic              usr_wr_en = 1'b0;
  logic [7:0]        usr_wr_data = '0;
  logic [7:0]        usr_rd_data;
  logic              i2c_wr_stb;
  logic [ADDR_W-1:0] i2c_wr_addr;
  logic [2:0]        debug_state;

  i2c_reg_bank_if bus ();

  i2c_reg_bank #(.I2C_ADDRESS(DEV), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i2c_bus     (bus),
    .usr_addr    (usr_addr),
    .usr_wr_en   (usr_wr_en),
    .usr_wr_data (usr_wr_data),
    .usr_rd_data (usr_rd_data),
    .i2c_wr_stb  (i2c_wr_stb),
    .i2c_wr_addr (i2c_wr_addr),
    .debug_state (debug_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 awaiting pointer, 2 writing, 3 reading.
  logic [7:0] m_regs [NREGS];
  int         m_ptr  = 0;
  int         m_mode = 0;

  logic [7:0] q_tx [$];
  int         q_wr [$];
  logic [7:0] q_rd [$];

  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  always @(posedge clk) rd_vld <= rd_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents a read byte, a write strobe or fabric data.
  int         stall_w = 0;
  logic [7:0] exp_b;
  int         exp_a;
  always @(negedge clk) begin
    if (rst) begin
      stall_w = 0;
    end else begin
      if (bus.stall) begin
        stall_w++;
      end else if (stall_w != 0) begin
        check("stall_width", 32'(stall_w), 32'd1);
        if (q_tx.size() == 0) unexpected("tx_data");
        else begin
          exp_b = q_tx.pop_front();
          check("tx_data", 32'(bus.i2c_data_tx), 32'(exp_b));
        end
        stall_w = 0;
      end
      if (i2c_wr_stb) begin
        if (q_wr.size() == 0) unexpected("wr_stb");
        else begin
          exp_a = q_wr.pop_front();
          check("wr_addr", 32'(i2c_wr_addr), 32'(exp_a));
        end
      end
      if (rd_vld) begin
        if (q_rd.size() == 0) unexpected("usr_rd");
        else begin
          exp_b = q_rd.pop_front();
          check("usr_rd_data", 32'(usr_rd_data), 32'(exp_b));
        end
      end
    end
  end

  function automatic logic [2:0] mode_state(input int mode);
    case (mode)
      1:       return 3'd1;
      2:       return 3'd2;
      3:       return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_state();
    check("debug_state", 32'(debug_state), 32'(mode_state(m_mode)));
  endtask

  task automatic send_addr(input logic [7:0] b, input bit fw = 1'b0, input int fa = 0,
                           input logic [7:0] fd = 8'h00);
    bus.i2c_addr_rw = b;
    bus.i2c_addr_rw_valid_stb = 1'b1;
    if (b[7:1] == DEV) begin
      if (b[0]) begin
        m_mode = 3;
        q_tx.push_back(m_regs[m_ptr]);
      end else m_mode = 1;
    end else m_mode = 0;
    idle(1);
    bus.i2c_addr_rw_valid_stb = 1'b0;
    if (fw) begin
      usr_addr = ADDR_W'(fa);
      usr_wr_data = fd;
      usr_wr_en = 1'b1;
      m_regs[fa] = fd;
    end
    idle(1);
    usr_wr_en = 1'b0;
    chk_state();
  endtask

  task automatic send_rx(input logic [7:0] b, input bit uw = 1'b0, input int ua = 0,
                         input logic [7:0] ud = 8'h00);
    bus.i2c_data_rx = b;
    bus.i2c_data_rx_valid_stb = 1'b1;
    if (uw) begin
      usr_addr = ADDR_W'(ua);
      usr_wr_data = ud;
      usr_wr_en = 1'b1;
      m_regs[ua] = ud;
    end
    if (m_mode == 1) begin
      m_ptr = int'(b) % NREGS;
      m_mode = 2;
    end else if (m_mode == 2) begin
      m_regs[m_ptr] = b;
      q_wr.push_back(m_ptr);
      m_ptr = (m_ptr + 1) % NREGS;
    end
    idle(1);
    bus.i2c_data_rx_valid_stb = 1'b0;
    usr_wr_en = 1'b0;
    idle(1);
    chk_state();
  endtask

  task automatic send_done();
    bus.i2c_data_tx_done_stb = 1'b1;
    if (m_mode == 3) begin
      m_ptr = (m_ptr + 1) % NREGS;
      q_tx.push_back(m_regs[m_ptr]);
    end
    idle(1);
    bus.i2c_data_tx_done_stb = 1'b0;
    idle(1);
    chk_state();
  endtask

  task automatic send_err();
    bus.i2c_error_stb = 1'b1;
    m_mode = 0;
    idle(1);
    bus.i2c_error_stb = 1'b0;
    idle(1);
    chk_state();
  endtask

  task automatic usr_wr(input int a, input logic [7:0] d);
    usr_addr = ADDR_W'(a);
    usr_wr_data = d;
    usr_wr_en = 1'b1;
    m_regs[a] = d;
    idle(1);
    usr_wr_en = 1'b0;
  endtask

  task automatic usr_rd(input int a);
    usr_addr = ADDR_W'(a);
    rd_req = 1'b1;
    q_rd.push_back(m_regs[a]);
    idle(1);
    rd_req = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NREGS); i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    m_mode = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i2c_addr_rw = '0;
    bus.i2c_addr_rw_valid_stb = 1'b0;
    bus.i2c_data_rx = '0;
    bus.i2c_data_rx_valid_stb = 1'b0;
    bus.i2c_data_tx_done_stb = 1'b0;
    bus.i2c_error_stb = 1'b0;
    model_reset();

    #2;
    check("rst_state", 32'(debug_state), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_tx", 32'(bus.i2c_data_tx), 32'd0);
    check("rst_usr_rd", 32'(usr_rd_data), 32'd0);
    check("rst_wr_stb", 32'(i2c_wr_stb), 32'd0);
    check("rst_wr_addr", 32'(i2c_wr_addr), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Basic write, then wrap-around write.
    send_addr(8'h84); send_rx(8'h03); send_rx(8'hAA); send_rx(8'hBB);
    send_addr(8'h84); send_rx(8'h0F); send_rx(8'h11); send_rx(8'h22);
    usr_rd(3); usr_rd(4); usr_rd(15); usr_rd(0);

    // Pointer write followed by repeated-start read of two bytes.
    send_addr(8'h84); send_rx(8'h03);
    send_addr(8'h85); send_done();
    usr_wr(5, 8'h5C);
    send_addr(8'h85);

    // Foreign address: nothing may change.
    send_addr(8'h90); send_rx(8'h01); send_rx(8'h55);
    usr_rd(1); usr_rd(5);

    // I2C and fabric write to the same register on the same edge.
    send_addr(8'h84); send_rx(8'h02);
    send_rx(8'h77, 1'b1, 2, 8'h99);
    usr_rd(2);
    // Different registers on the same edge both land.
    send_rx(8'h31, 1'b1, 9, 8'h46);
    usr_rd(3); usr_rd(9);

    // Fabric write during the fetch cycle: the fetch keeps the old value.
    send_addr(8'h84); send_rx(8'h06);
    usr_wr(6, 8'h3C);
    send_addr(8'h85, 1'b1, 6, 8'hC3);
    usr_rd(6);

    // Error aborts a write; the pointer is kept.
    send_addr(8'h84); send_rx(8'h0A); send_rx(8'hE1); send_err(); send_rx(8'hE2); send_done();
    send_addr(8'h85);

    // Randomized traffic.
    repeat (80) begin
      case ($urandom_range(0, 7))
        0: begin
          send_addr({DEV, 1'b0});
          send_rx(8'($urandom));
          repeat ($urandom_range(0, 4)) send_rx(8'($urandom));
        end
        1: begin
          send_addr({DEV, 1'b1});
          repeat ($urandom_range(0, 3)) send_done();
        end
        2: send_addr(8'($urandom));
        3: send_rx(8'($urandom));
        4: send_err();
        5: send_done();
        6: usr_wr(int'($urandom_range(0, NREGS - 1)), 8'($urandom));
        default: usr_rd(int'($urandom_range(0, NREGS - 1)));
      endcase
    end

    // Async reset in the middle of a read.
    usr_wr(0, 8'hA5);
    send_addr(8'h84); send_rx(8'h00);
    send_addr(8'h85);
    idle(1);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(debug_state), 32'd0);
    check("mid_rst_tx", 32'(bus.i2c_data_tx), 32'd0);
    check("mid_rst_stall", 32'(bus.stall), 32'd0);
    check("mid_rst_wr_stb", 32'(i2c_wr_stb), 32'd0);
    model_reset();
    idle(2);
    rst = 1'b0;
    idle(1);
    for (int i = 0; i < int'(NREGS); i++) usr_rd(i);
    // Pointer restarts at 0 after reset.
    usr_wr(0, 8'h5A);
    usr_wr(1, 8'h6B);
    send_addr(8'h85); send_done();

    idle(4);
    for (int i = 0; i < int'(NREGS); i++) usr_rd(i);
    idle(3);
    check("q_tx_empty", 32'(q_tx.size()), 32'd0);
    check("q_wr_empty", 32'(q_wr.size()), 32'd0);
    check("q_rd_empty", 32'(q_rd.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_reg_bank.md
Name: i2c_reg_bank

Overview:
Register-file back end that sits directly downstream of the I2C simple slave and consumes its strobes. It implements the usual pointer-based register protocol:
- the first byte of a write transaction sets the register pointer;
- later write bytes are stored at the pointer, which auto-increments;
- read transactions return the register at the pointer, which auto-increments.

It drives the slave's stall input (clock stretching) while fetching read data. It also exposes a fabric-side port so local logic can read and write the same registers.

Parameters:
I2C_ADDRESS, 7'h42, 7-bit address; must equal the slave's address (the slave strobes every address, matched or not).
ADDR_W, 4, register pointer width; the bank holds 2**ADDR_W 8-bit registers.

Ports:
clk  in  1  system clock; the only clock
rst  in  1  asynchronous, active-high reset
i2c_addr_rw  in  8  {addr[6:0], rw} from slave
i2c_addr_rw_valid_stb  in  1  1-cycle pulse, i2c_addr_rw valid
i2c_data_rx  in  8  received data byte
i2c_data_rx_valid_stb  in  1  1-cycle pulse, i2c_data_rx valid
i2c_data_tx  out  8  byte the slave loads for transmission
i2c_data_tx_done_stb  in  1  1-cycle pulse, slave finished sending i2c_data_tx
i2c_error_stb  in  1  1-cycle pulse, slave protocol error
stall  out  1  to slave; high = stretch SCL
usr_addr  in  ADDR_W  fabric register select
usr_wr_en  in  1  fabric write enable
usr_wr_data  in  8  fabric write data
usr_rd_data  out  8  registered read of regs[usr_addr]
i2c_wr_stb  out  1  1-cycle pulse, I2C wrote a register
i2c_wr_addr  out  ADDR_W  register index of last I2C write
debug_state  out  3  current FSM state

Behaviour:
- Reset (async, rst=1): FSM to ST_IDLE. ptr=0. All registers=8'h00. i2c_data_tx=0. usr_rd_data=0. i2c_wr_stb=0. i2c_wr_addr=0. stall=0.
- Address match: addr_match = (i2c_addr_rw[7:1]==I2C_ADDRESS).
- States: ST_IDLE=0, ST_PTR=1, ST_WR=2, ST_FETCH=3, ST_RD=4.
- Event priority, checked each cycle:
  1. i2c_error_stb -> ST_IDLE; ptr unchanged.
  2. i2c_addr_rw_valid_stb:
     - no addr_match -> ST_IDLE;
     - addr_match && rw=0 -> ST_PTR;
     - addr_match && rw=1 -> ST_FETCH.
     This applies from any state, which also covers a repeated start.
  3. State-specific events below.
- ST_PTR: on rx_stb, ptr <= i2c_data_rx[ADDR_W-1:0] (upper bits ignored) -> ST_WR.
- ST_WR: on rx_stb:
  - regs[ptr] <= i2c_data_rx;
  - i2c_wr_addr <= ptr; i2c_wr_stb pulses next cycle;
  - ptr <= ptr+1, wrapping from 2**ADDR_W-1 to 0;
  - stay in ST_WR.
- ST_FETCH: lasts exactly 1 cycle.
  - i2c_data_tx <= regs[ptr] at the end of the cycle -> ST_RD.
  - stall = 1 combinationally while in ST_FETCH; 0 in every other state.
  - The slave ACK phase spans many clk cycles, so i2c_data_tx is valid before the slave leaves its stall state.
- ST_RD: on i2c_data_tx_done_stb, ptr <= ptr+1 (wrapping) -> ST_FETCH, which prefetches the next byte. i2c_data_tx holds its value otherwise.
- Other cases:
  - rx_stb in ST_IDLE/ST_FETCH/ST_RD is ignored.
  - tx_done_stb outside ST_RD is ignored.
- ptr persists across transactions (STOP is not signalled). A write of the pointer byte followed by a repeated-start read returns regs[new ptr].
- Fabric port:
  - usr_rd_data <= regs[usr_addr] every cycle (1-cycle latency; shows the pre-write value when a write lands on the same edge).
  - usr_wr_en writes regs[usr_addr] <= usr_wr_data.
- Simultaneous I2C write and fabric write to the same register on the same edge: the I2C write wins and the fabric write is dropped. Writes to different registers both complete.
- A fabric write in the same cycle as ST_FETCH to regs[ptr]: the fetch captures the old value.
- debug_state = state encoding.

Test Plan:
- Write 0x84,[0x03,0xAA,0xBB] -> regs[3]=0xAA, regs[4]=0xBB; i2c_wr_stb pulses twice with i2c_wr_addr 3 then 4; ptr=5.
- Write 0x84,[0x0F,0x11,0x22] -> regs[15]=0x11, regs[0]=0x22 (wrap); ptr=1.
- Write 0x84,[0x03], then repeated-start read 0x85 for 2 bytes -> i2c_data_tx=0xAA, stall high exactly 1 cycle after the addr strobe; after tx_done, i2c_data_tx=0xBB; ptr=5.
- Addr byte 0x90 (address 0x48) then rx strobes 0x01,0x55 -> FSM in ST_IDLE; no register changes; no i2c_wr_stb; stall stays 0.
- In ST_WR with ptr=2: i2c_data_rx=0x77 and usr_wr_en with usr_addr=2, usr_wr_data=0x99 on the same edge -> regs[2]=0x77; next cycle usr_rd_data=0x77.
- rst asserted mid-read (ST_RD) -> immediately ST_IDLE, i2c_data_tx=0, ptr=0, all regs 0, stall=0.
